ddr_test_uart_report: RTL

DDR_TEST_UART_REPORT -- requirements
Module: ddr_test_uart_report

---
 rtl/ddr_test_uart_report_if.sv | 20 ++
 rtl/ddr_test_uart_report.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ddr_test_uart_report_if.sv
// Result handshake from the DDR3 test plus the serial report line and status.
interface ddr_test_uart_report_if;
   logic        test_done;
   logic        test_pass;
   logic [15:0] err_count;
   logic        uart_txp;
   logic        busy;
   logic [1:0]  dbg_state;

   // test_done is a one-cycle pulse; test_pass/err_count are only meaningful while it is high.
   modport master (
      output test_done, test_pass, err_count,
      input  uart_txp, busy, dbg_state
   );

   modport slave (
      input  test_done, test_pass, err_count,
      output uart_txp, busy, dbg_state
   );
endinterface

// File: rtl/ddr_test_uart_report.sv
// Sends an 11-byte "PASS xxxx\r\n" / "FAIL xxxx\r\n" report over an 8N1 UART for each
// DDR3 test result, with a single-entry pending slot for results arriving mid-report.
module ddr_test_uart_report #(
   parameter int CLK_FREQ  = 27_000_000,
   parameter int BAUD_RATE = 115_200
) (
   input logic                    clk,
   input logic                    rst,
   ddr_test_uart_report_if.slave  bus
);
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_e;

   state_e         state_q, state_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic [2:0]     bit_idx_q, bit_idx_d;
   logic [3:0]     byte_idx_q, byte_idx_d;
   logic           pass_q, pass_d;
   logic [15:0]    err_q, err_d;
   logic           pend_q, pend_d;
   logic           pend_pass_q, pend_pass_d;
   logic [15:0]    pend_err_q, pend_err_d;
   logic           txp_q, txp_d;
   logic           busy_q, busy_d;
   logic           timer_last;
   logic [7:0]     cur_char;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   function automatic logic [7:0] report_char(input logic [3:0] idx, input logic pass,
                                              input logic [15:0] err);
      case (idx)
         4'd0:    return pass ? 8'h50 : 8'h46;
         4'd1:    return 8'h41;
         4'd2:    return pass ? 8'h53 : 8'h49;
         4'd3:    return pass ? 8'h53 : 8'h4C;
         4'd4:    return 8'h20;
         4'd5:    return hex_char(err[15:12]);
         4'd6:    return hex_char(err[11:8]);
         4'd7:    return hex_char(err[7:4]);
         4'd8:    return hex_char(err[3:0]);
         4'd9:    return 8'h0D;
         default: return 8'h0A;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         bit_idx_q   <= '0;
         byte_idx_q  <= '0;
         pass_q      <= 1'b0;
         err_q       <= '0;
         pend_q      <= 1'b0;
         pend_pass_q <= 1'b0;
         pend_err_q  <= '0;
         txp_q       <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         bit_idx_q   <= bit_idx_d;
         byte_idx_q  <= byte_idx_d;
         pass_q      <= pass_d;
         err_q       <= err_d;
         pend_q      <= pend_d;
         pend_pass_q <= pend_pass_d;
         pend_err_q  <= pend_err_d;
         txp_q       <= txp_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      bit_idx_d   = bit_idx_q;
      byte_idx_d  = byte_idx_q;
      pass_d      = pass_q;
      err_d       = err_q;
      pend_d      = pend_q;
      pend_pass_d = pend_pass_q;
      pend_err_d  = pend_err_q;
      timer_last  = (timer_q == TIMER_LAST);

      if (state_q != IDLE) begin
         timer_d = timer_last ? '0 : timer_q + TW'(1);
         // A result arriving mid-report overwrites any earlier pending one.
         if (bus.test_done) begin
            pend_d      = 1'b1;
            pend_pass_d = bus.test_pass;
            pend_err_d  = bus.err_count;
         end
      end

      case (state_q)
         IDLE: begin
            if (bus.test_done) begin
               state_d    = START;
               pass_d     = bus.test_pass;
               err_d      = bus.err_count;
               timer_d    = '0;
               bit_idx_d  = '0;
               byte_idx_d = '0;
            end
         end
         START: begin
            if (timer_last) begin
               state_d   = DATA;
               bit_idx_d = '0;
            end
         end
         DATA: begin
            if (timer_last) begin
               if (bit_idx_q == 3'd7) state_d = STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end
         end
         STOP: begin
            if (timer_last) begin
               if (byte_idx_q != 4'd10) begin
                  byte_idx_d = byte_idx_q + 4'd1;
                  state_d    = START;
               end else begin
                  byte_idx_d = '0;
                  // A pulse in this very cycle counts as pending and wins over an older one.
                  if (pend_q || bus.test_done) begin
                     state_d = START;
                     pass_d  = bus.test_done ? bus.test_pass : pend_pass_q;
                     err_d   = bus.test_done ? bus.err_count : pend_err_q;
                     pend_d  = 1'b0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level is registered from the next-state view so the output has no input path.
   always_comb begin
      cur_char = report_char(byte_idx_d, pass_d, err_d);
      busy_d   = (state_d != IDLE);
      case (state_d)
         START:   txp_d = 1'b0;
         DATA:    txp_d = cur_char[bit_idx_d];
         default: txp_d = 1'b1;
      endcase
   end

   assign bus.uart_txp  = txp_q;
   assign bus.busy      = busy_q;
   assign bus.dbg_state = state_q;
endmodule
